// File: rtl/bus_arbiter_round_robin.sv
// Round-robin arbiter for the shared snoopy bus. A requester keeps the bus until it drops its request.
// Latency: request sampled at edge k, grant visible after edge k. All outputs are registered.
// Backpressure: level request/grant only. At least one idle (grant==0) cycle separates two owners.
//
// Ports:
//   clock      - single clock, all state updates on posedge
//   reset      - asynchronous, active-low; clears all state and drops the grant immediately
//   request    - request[i]=1: device i wants / keeps the bus
//   grant      - one-hot or zero; grant[i]=1: device i owns the bus
//   ownerValid - 1 iff grant != 0
//   owner      - index of the current owner, 0 when ownerValid=0
//   preempted  - one-cycle pulse when a grant is revoked by the hold timeout
//
// Optional feature macro: BUS_ARBITER_TIMEOUT_EN
//   defined   - an owner holding the bus for MAX_HOLD_CYCLES cycles is preempted when another
//               device is waiting; with no other requester it keeps the bus.
//   undefined - no hold counter; ownership is unbounded and preempted is tied to 0.

module bus_arbiter_round_robin #(
    parameter  int NUMBER_OF_REQUESTERS = 4,
    parameter  int MAX_HOLD_CYCLES      = 64,
    localparam int OWNER_WIDTH          = $clog2(NUMBER_OF_REQUESTERS)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUMBER_OF_REQUESTERS-1:0] request,
    output logic [NUMBER_OF_REQUESTERS-1:0] grant,
    output logic                            ownerValid,
    output logic [OWNER_WIDTH-1:0]          owner,
    output logic                            preempted
);

    // Elaboration-time sanity checks on the configuration.
    if (NUMBER_OF_REQUESTERS < 2) begin : g_bad_requesters
        $error("bus_arbiter_round_robin: NUMBER_OF_REQUESTERS must be >= 2");
    end
    if (MAX_HOLD_CYCLES < 1) begin : g_bad_hold
        $error("bus_arbiter_round_robin: MAX_HOLD_CYCLES must be >= 1");
    end

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_t;

    state_t                            state_q;
    logic [OWNER_WIDTH-1:0]            ptr_q;
    logic [NUMBER_OF_REQUESTERS-1:0]   grant_q;
    logic                              ownerValid_q;
    logic [OWNER_WIDTH-1:0]            owner_q;

    logic                              pick_vld_d;
    logic [OWNER_WIDTH-1:0]            pick_idx_d;
    logic [OWNER_WIDTH-1:0]            cand_d;
    logic [NUMBER_OF_REQUESTERS-1:0]   pick_grant_d;
    logic [OWNER_WIDTH-1:0]            rel_ptr_d;

    // First requester found starting at ptr_q and wrapping modulo N. The loop runs from the
    // farthest offset down so the nearest candidate is the one left standing.
    always_comb begin
        pick_vld_d = 1'b0;
        pick_idx_d = '0;
        cand_d     = '0;
        for (int off = NUMBER_OF_REQUESTERS - 1; off >= 0; off--) begin
            cand_d = OWNER_WIDTH'((int'(ptr_q) + off) % NUMBER_OF_REQUESTERS);
            if (request[cand_d]) begin
                pick_vld_d = 1'b1;
                pick_idx_d = cand_d;
            end
        end
    end

    assign pick_grant_d = {{(NUMBER_OF_REQUESTERS-1){1'b0}}, 1'b1} << pick_idx_d;

    // After a release the releasing device becomes lowest priority. Explicit wrap keeps this
    // correct for non-power-of-2 requester counts.
    assign rel_ptr_d = (owner_q == OWNER_WIDTH'(NUMBER_OF_REQUESTERS - 1))
                     ? '0 : owner_q + OWNER_WIDTH'(1);

`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int HOLD_WIDTH = (MAX_HOLD_CYCLES > 1) ? $clog2(MAX_HOLD_CYCLES) : 1;

    logic [HOLD_WIDTH-1:0] holdCount_q;
    logic                  preempted_q;
    logic                  hold_at_max_d;
    logic                  others_pending_d;

    assign hold_at_max_d    = (holdCount_q == HOLD_WIDTH'(MAX_HOLD_CYCLES - 1));
    assign others_pending_d = |(request & ~grant_q);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            grant_q      <= '0;
            ownerValid_q <= 1'b0;
            owner_q      <= '0;
`ifdef BUS_ARBITER_TIMEOUT_EN
            holdCount_q  <= '0;
            preempted_q  <= 1'b0;
`endif
        end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            preempted_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_vld_d) begin
                        grant_q      <= pick_grant_d;
                        owner_q      <= pick_idx_d;
                        ownerValid_q <= 1'b1;
                        state_q      <= GRANTED;
`ifdef BUS_ARBITER_TIMEOUT_EN
                        holdCount_q  <= '0;
`endif
                    end
                end
                GRANTED: begin
                    // Release takes precedence; other requests wait for the following IDLE
                    // cycle, which also provides the bus turnaround gap.
                    if (!request[owner_q]) begin
                        grant_q      <= '0;
                        ownerValid_q <= 1'b0;
                        owner_q      <= '0;
                        ptr_q        <= rel_ptr_d;
                        state_q      <= IDLE;
                    end
`ifdef BUS_ARBITER_TIMEOUT_EN
                    else if (hold_at_max_d && others_pending_d) begin
                        grant_q      <= '0;
                        ownerValid_q <= 1'b0;
                        owner_q      <= '0;
                        ptr_q        <= rel_ptr_d;
                        preempted_q  <= 1'b1;
                        state_q      <= IDLE;
                    end else if (!hold_at_max_d) begin
                        // Saturates: a lone owner keeps the bus with the counter parked at max.
                        holdCount_q  <= holdCount_q + HOLD_WIDTH'(1);
                    end
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_q;
    assign ownerValid = ownerValid_q;
    assign owner      = owner_q;
`ifdef BUS_ARBITER_TIMEOUT_EN
    assign preempted  = preempted_q;
`else
    assign preempted  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter_round_robin.sv
// Directed bench for bus_arbiter_round_robin with four requesters.
// Inputs change 1 time unit after posedge; outputs are sampled there or on the negedge.
// A negedge monitor checks one-hot/zero grant and ownerValid consistency every cycle.

module tb_bus_arbiter_round_robin;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;
    logic         owner_vld;
    logic [1:0]   owner;
    logic         preempted;

    int   n_chk  = 0;
    int   n_pass = 0;
    logic mon_en = 1'b0;

    logic [N-1:0] cur;
    logic [N-1:0] nxt;

    always #5 clk = ~clk;

    bus_arbiter_round_robin #(
        .NUMBER_OF_REQUESTERS (N),
        .MAX_HOLD_CYCLES      (8)
    ) dut (
        .clock      (clk),
        .reset      (rst_n),
        .request    (req),
        .grant      (grant),
        .ownerValid (owner_vld),
        .owner      (owner),
        .preempted  (preempted)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [1:0] idx_of(input logic [N-1:0] g);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < N; i++) if (g[i]) idx = 2'(i);
        return idx;
    endfunction

    // Grant, ownerValid and owner must all agree with the expected one-hot grant.
    task automatic exp_state(input string tag, input logic [N-1:0] g);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".ownerValid"}, 32'(owner_vld), 32'(g != '0));
        chk({tag, ".owner"}, 32'(owner), 32'(idx_of(g)));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en)
            chk("onehot0", 32'($onehot0(grant) && (owner_vld == (grant != '0))), 32'd1);
    end

    initial begin
        // Reset held low with all devices requesting.
        rst_n = 1'b0;
        req   = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        exp_state("reset", 4'b0000);
        chk("reset.preempted", 32'(preempted), 32'd0);

        rst_n  = 1'b1;
        mon_en = 1'b1;
        tick();
        exp_state("rst_release", 4'b0001);

        // Round robin with all requesting: each owner holds 3 cycles then drops for 1.
        for (int k = 0; k < N; k++) begin
            cur = 4'b0001 << k;
            nxt = 4'b0001 << ((k + 1) % N);
            tick(); chk("rr_hold1", 32'(grant), 32'(cur));
            tick(); chk("rr_hold2", 32'(grant), 32'(cur));
            req = 4'b1111 & ~cur;
            tick(); exp_state("rr_gap", 4'b0000);
            req = 4'b1111;
            tick(); exp_state("rr_next", nxt);
        end

        // Owner 0 drops, 3 alone -> 3; owner 3 releases while 0 and 1 raise.
        req = 4'b1000;
        tick(); exp_state("wrap_rel0", 4'b0000);
        tick(); exp_state("wrap_pick3", 4'b1000);
        req = 4'b0011;
        tick(); exp_state("wrap_gap", 4'b0000);
        tick(); exp_state("wrap_to0", 4'b0001);
        tick(); exp_state("others_ignored", 4'b0001);

        // Device 2 gets the bus, then async reset mid-ownership.
        req = 4'b0100;
        tick(); exp_state("pre_rst_rel", 4'b0000);
        tick(); exp_state("pre_rst_own2", 4'b0100);
        tick(); chk("pre_rst_hold", 32'(grant), 32'(4'b0100));
        #2 rst_n = 1'b0;
        #1 exp_state("async_rst", 4'b0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick(); exp_state("rst_regrant", 4'b0100);

        // 2 releases with 0 and 3 requesting: ptr=3 so 3 wins over 0.
        req = 4'b1001;
        tick(); exp_state("rel2_gap", 4'b0000);
        tick(); exp_state("rel2_pick3", 4'b1000);

        // Owner re-raises in the idle cycle right after release.
        req = 4'b0000;
        tick(); exp_state("reraise_gap", 4'b0000);
        req = 4'b1000;
        tick(); exp_state("reraise", 4'b1000);

        // Device 0 takes the bus, device 1 starts waiting.
        req = 4'b0001;
        tick(); exp_state("hold_rel3", 4'b0000);
        tick(); exp_state("hold_own0", 4'b0001);
        req = 4'b0011;
`ifdef BUS_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_hold.grant", 32'(grant), 32'(4'b0001));
            chk("to_hold.preempted", 32'(preempted), 32'd0);
        end
        tick();
        exp_state("to_revoke", 4'b0000);
        chk("to_revoke.preempted", 32'(preempted), 32'd1);
        tick();
        exp_state("to_next", 4'b0010);
        chk("to_next.preempted", 32'(preempted), 32'd0);

        // Device 0 alone keeps the bus indefinitely.
        req = 4'b0001;
        tick(); exp_state("alone_rel1", 4'b0000);
        tick(); exp_state("alone_own0", 4'b0001);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("alone.preempted", 32'(preempted), 32'd0);
        end
        exp_state("alone_end", 4'b0001);

        // Counter is saturated, so a new requester triggers revocation at the next edge.
        req = 4'b0011;
        tick();
        exp_state("sat_revoke", 4'b0000);
        chk("sat_revoke.preempted", 32'(preempted), 32'd1);
        tick();
        exp_state("sat_next", 4'b0010);
        req = 4'b0000;
        tick(); exp_state("sat_rel", 4'b0000);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("unbounded.grant", 32'(grant), 32'(4'b0001));
            chk("unbounded.preempted", 32'(preempted), 32'd0);
        end
        req = 4'b0000;
        tick(); exp_state("unbounded_rel", 4'b0000);
`endif

        // Park ptr at 2 via a short ownership of device 1.
        req = 4'b0010;
        tick(); exp_state("park_own1", 4'b0010);
        req = 4'b0000;
        tick(); exp_state("park_rel", 4'b0000);

        // Devices 1 and 2 steady; each owner releases for one cycle every 5 cycles.
        req = 4'b0110;
        tick(); exp_state("alt_first", 4'b0100);
        cur = 4'b0100;
        for (int r = 0; r < 6; r++) begin
            repeat (4) begin
                tick();
                chk("alt_hold", 32'(grant), 32'(cur));
            end
            req = 4'b0110 & ~cur;
            tick(); chk("alt_gap", 32'(grant), 32'd0);
            req = 4'b0110;
            nxt = (cur == 4'b0100) ? 4'b0010 : 4'b0100;
            tick(); exp_state("alt_next", nxt);
            cur = nxt;
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
